if_id_reg_tmr: RTL and testbench

- Triple-modular-redundant IF/ID pipeline register.
- Sits between instruction fetch and decode, directly downstream of the branch/jump hazard unit; consumes its IF/ID flush and the load-use stall.
- Holds the fetched PC and instruction in three independent copies, drives decode from a bitwise majority vote, and scrubs single-copy upsets every cycle.
- Reports and counts corrected upsets; a fault-injection port lets the bench corrupt one copy.

---
 rtl/cpu_tmr_pkg.sv | 16 +
 rtl/tmr_vote3.sv | 21 ++
 rtl/if_id_reg_tmr.sv | 88 ++++++++
 tb/tb_if_id_reg_tmr.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_tmr_pkg.sv
// Shared definitions for the triple-modular-redundant pipeline registers:
// default NOP word, per-bit majority function and the stored-word width.
package cpu_tmr_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  // Width of one stored copy {valid, pc, instr}.
  function automatic int tmr_word_w(input int pc_w, input int instr_w);
    return 1 + pc_w + instr_w;
  endfunction

endpackage

// File: rtl/tmr_vote3.sv
// Bitwise 2-of-3 voter with a flag raised whenever the three copies disagree anywhere.
module tmr_vote3
  import cpu_tmr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] voted,
  output logic         mismatch
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign voted[gi] = maj3(a[gi], b[gi], c[gi]);
  end

  // Equal copies pairwise a==b and b==c imply all three agree.
  assign mismatch = |((a ^ b) | (b ^ c));

endmodule

// File: rtl/if_id_reg_tmr.sv
// IF/ID pipeline register stored in three copies; decode sees the majority vote
// and every edge rewrites all copies from one voted/selected value (scrubbing).
module if_id_reg_tmr
  import cpu_tmr_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 CNT_W     = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            stall,
  input  logic                            if_valid,
  input  logic [PC_W-1:0]                 if_pc,
  input  logic [INSTR_W-1:0]              if_instr,
  output logic                            id_valid,
  output logic [PC_W-1:0]                 id_pc,
  output logic [INSTR_W-1:0]              id_instr,
  output logic                            tmr_err,
  output logic [CNT_W-1:0]                tmr_err_cnt,
  input  logic                            err_clr,
  input  logic                            inj_en,
  input  logic [1:0]                      inj_sel,
  input  logic [1+PC_W+INSTR_W-1:0]       inj_mask
);

  localparam int W = tmr_word_w(PC_W, INSTR_W);
  localparam logic [W-1:0] EMPTY_WORD = {1'b0, {PC_W{1'b0}}, NOP_INSTR};

  logic [W-1:0]     copy_reg [3];
  logic [W-1:0]     voted_word;
  logic [W-1:0]     next_word;
  logic             mismatch;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  tmr_vote3 #(.W(W)) u_vote (
    .a        (copy_reg[0]),
    .b        (copy_reg[1]),
    .c        (copy_reg[2]),
    .voted    (voted_word),
    .mismatch (mismatch)
  );

  always_comb begin
    next_word = {if_valid, if_pc, if_instr};
    if (flush) begin
      next_word = EMPTY_WORD;
    end else if (stall) begin
      next_word = voted_word;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_copy
    logic hit;
    assign hit = inj_en && (inj_sel == 2'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        copy_reg[gi] <= EMPTY_WORD;
      end else begin
        copy_reg[gi] <= hit ? (next_word ^ inj_mask) : next_word;
      end
    end
  end

  // Clear wins over a simultaneous increment; the error pulse is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      err_reg <= mismatch;
      if (err_clr) begin
        cnt_reg <= '0;
      end else if (mismatch && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign {id_valid, id_pc, id_instr} = voted_word;
  assign tmr_err     = err_reg;
  assign tmr_err_cnt = cnt_reg;

endmodule

// File: tb/tb_if_id_reg_tmr.sv
// Scoreboard bench for if_id_reg_tmr: each driven cycle pushes its expected
// post-edge outputs, which are popped and compared one cycle later.
module tb_if_id_reg_tmr;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 8;
  localparam int W       = 1 + PC_W + INSTR_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               stall = 1'b0;
  logic               if_valid = 1'b0;
  logic [PC_W-1:0]    if_pc = '0;
  logic [INSTR_W-1:0] if_instr = '0;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic               tmr_err;
  logic [CNT_W-1:0]   tmr_err_cnt;
  logic               err_clr = 1'b0;
  logic               inj_en = 1'b0;
  logic [1:0]         inj_sel = 2'd3;
  logic [W-1:0]       inj_mask = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string              name;
    logic               v;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               err;
    logic [CNT_W-1:0]   cnt;
  } exp_t;

  exp_t sb[$];

  // Reference state: the logically held word, whether stored copies disagree, count.
  logic               m_v;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic               m_mm;
  logic [CNT_W-1:0]   m_cnt;

  if_id_reg_tmr #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .tmr_err(tmr_err), .tmr_err_cnt(tmr_err_cnt), .err_clr(err_clr),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_v = 1'b0; m_pc = '0; m_instr = 32'h0000_0000; m_mm = 1'b0; m_cnt = '0;
    sb.delete();
  endtask

  // Applies the currently driven inputs for one clock edge and checks the result.
  task automatic cycle(input string name);
    exp_t e;
    e.name = name;
    e.err  = m_mm;
    if (err_clr)                   e.cnt = '0;
    else if (m_mm && m_cnt != 255) e.cnt = m_cnt + 8'd1;
    else                           e.cnt = m_cnt;
    if (flush) begin
      e.v = 1'b0; e.pc = '0; e.instr = 32'h0000_0000;
    end else if (stall) begin
      e.v = m_v; e.pc = m_pc; e.instr = m_instr;
    end else begin
      e.v = if_valid; e.pc = if_pc; e.instr = if_instr;
    end
    sb.push_back(e);
    m_v = e.v; m_pc = e.pc; m_instr = e.instr; m_cnt = e.cnt;
    m_mm = inj_en && (inj_sel != 2'd3) && (inj_mask != '0);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if ({id_valid, id_pc, id_instr} !== {e.v, e.pc, e.instr}) begin
      miscompares++;
      $display("FAIL %s word: got v=%0b pc=%h instr=%h, want v=%0b pc=%h instr=%h",
               e.name, id_valid, id_pc, id_instr, e.v, e.pc, e.instr);
    end
    vectors++;
    if (tmr_err !== e.err) begin
      miscompares++;
      $display("FAIL %s tmr_err: got %0b, want %0b", e.name, tmr_err, e.err);
    end
    vectors++;
    if (tmr_err_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL %s tmr_err_cnt: got %0d, want %0d", e.name, tmr_err_cnt, e.cnt);
    end
    $display("cycle %-12s v=%0b pc=%h instr=%h err=%0b cnt=%0d",
             e.name, id_valid, id_pc, id_instr, tmr_err, tmr_err_cnt);
  endtask

  task automatic idle_inputs();
    flush = 0; stall = 0; err_clr = 0; inj_en = 0; inj_sel = 2'd3; inj_mask = '0;
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if ({id_valid, id_pc, id_instr, tmr_err, tmr_err_cnt} !== {1'b0, 32'h0, 32'h0, 1'b0, 8'h0}) begin
      miscompares++;
      $display("FAIL %s: got v=%0b pc=%h instr=%h err=%0b cnt=%0d, want all reset values",
               name, id_valid, id_pc, id_instr, tmr_err, tmr_err_cnt);
    end
    $display("check %s v=%0b pc=%h instr=%h err=%0b cnt=%0d",
             name, id_valid, id_pc, id_instr, tmr_err, tmr_err_cnt);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_load();
    idle_inputs();
    if_valid = 1; if_pc = 32'h100; if_instr = 32'h2108_0001;
    cycle("load");
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      if_pc = 32'h104 + 32'(4 * (i % 2)); if_instr = 32'hA000_0000 + 32'(i);
      cycle("stall");
    end
    stall = 0; if_pc = 32'h108; if_instr = 32'h0000_1108;
    cycle("stall_rel");
  endtask

  task automatic test_flush_stall();
    flush = 1; stall = 1; if_pc = 32'h10C; if_instr = 32'h1234_5678;
    cycle("flush_stall");
    flush = 0; stall = 0; if_pc = 32'h110; if_instr = 32'h0BAD_F00D;
    cycle("refill");
  endtask

  task automatic test_inject();
    inj_en = 1; inj_sel = 2'd1; inj_mask = W'(1);
    if_pc = 32'h114; if_instr = 32'h0000_0F0F;
    cycle("inj");
    idle_inputs(); if_pc = 32'h118; if_instr = 32'h0000_0F10;
    cycle("inj_err");
    if_pc = 32'h11C; if_instr = 32'h0000_0F11;
    cycle("inj_clean");
    // Upset while stalled: the scrub must restore the held word.
    stall = 1; inj_en = 1; inj_sel = 2'd2; inj_mask = {1'b1, 32'hFFFF_FFFF, 32'h8000_0001};
    cycle("inj_stall");
    idle_inputs(); stall = 1;
    cycle("stall_scrub");
    idle_inputs(); inj_en = 1; inj_sel = 2'd3; inj_mask = '1;
    cycle("inj_none");
    idle_inputs();
    cycle("after_none");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      inj_en = 1; inj_sel = 2'(i % 3);
      inj_mask = {1'($urandom), $urandom, $urandom} | W'(1 << (i % 60));
      flush = ($urandom_range(0, 9) == 0); stall = ($urandom_range(0, 3) == 0);
      if_valid = 1'($urandom); if_pc = $urandom; if_instr = $urandom;
      cycle("sat");
    end
    idle_inputs(); err_clr = 1; if_pc = 32'h200; if_instr = 32'h0000_0200;
    cycle("clr_pending");
    err_clr = 0;
    cycle("after_clr");
  endtask

  task automatic test_async_reset();
    idle_inputs(); if_valid = 1; if_pc = 32'h300; if_instr = 32'h0000_0300;
    cycle("pre_rst");
    stall = 1; inj_en = 1; inj_sel = 2'd0; inj_mask = W'(5);
    cycle("stall_inj");
    inj_en = 0;
    cycle("stall_err");
    stall = 1; inj_en = 1; inj_sel = 2'd1; inj_mask = W'(2);
    cycle("stall_inj2");
    #3;
    rst_n = 0;
    #1;
    check_reset_values("async_rst");
    idle_inputs();
    @(posedge clk);
    #1;
    check_reset_values("rst_held");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    if_valid = 1; if_pc = 32'h400; if_instr = 32'h0000_0400;
    cycle("post_rst");
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      if_valid = 1'($urandom); if_pc = 32'h1000 + 32'(4 * i); if_instr = $urandom;
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 5) == 0);
      cycle("b2b");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_inject();
    test_saturate();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
